mem_arbiter: RTL

Arbitrates one shared single-port word memory (board SRAM or on-chip RAM) between the CPU instruction-fetch port and the CPU data port. It sequences each access with a programmable wait-state count and returns data to the winning requester with a one-cycle acknowledge pulse. It sits between `cpu` and the memory pins in the top-level wrapper, in place of the hard-wired combinational instruction ROM.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding,
// requester IDs and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter that paces each memory access; it parks at 0
// and reports zero so the arbiter knows when the memory data is valid.
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and data
// ports: data-priority arbitration with a streak limit, programmable wait states.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                timer_load, timer_zero, any_req, pick_i;

  mem_wait_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (4'(WAIT_CYCLES)),
    .zero  (timer_zero)
  );

  assign any_req = i_req | d_req;
  // Instruction wins only when it is actually requesting and data either is
  // absent or has used up its streak allowance.
  assign pick_i  = i_req & (~d_req | (streak_q == STREAK_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= REQ_I;
      streak_q    <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      streak_q    <= streak_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (timer_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    win_d       = win_q;
    streak_d    = streak_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    timer_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_req) streak_d = '0;
        if (any_req) begin
          timer_load = 1'b1;
          mem_ce_d   = 1'b1;
          if (pick_i) begin
            win_d      = REQ_I;
            mem_addr_d = i_addr;
            mem_we_d   = 1'b0;
            mem_be_d   = BE_ALL;
            streak_d   = '0;
          end else begin
            win_d       = REQ_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_wdata_d = d_wdata;
            if (i_req && streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      ACCESS: begin
        if (timer_zero) begin
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          mem_be_d = 4'b0000;
          if (win_q == REQ_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
